// File: rtl/sram_timer_periph.sv
// Data-SRAM-port peripheral: LED register, synchronized switches and a 32-bit
// compare-match timer, answering reads with the same one-cycle latency as the data RAM.
module sram_timer_periph #(
  parameter logic [15:0] BASE_HI = 16'h1FAF,
  parameter int          LED_W   = 16,
  parameter int          SW_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_wen,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  sw,
  output logic             timer_int
);

  localparam logic [13:0] A_LED   = 14'd0;
  localparam logic [13:0] A_SW    = 14'd1;
  localparam logic [13:0] A_COUNT = 14'd2;
  localparam logic [13:0] A_CMP   = 14'd3;
  localparam logic [13:0] A_CTRL  = 14'd4;
  localparam logic [13:0] A_STAT  = 14'd5;

  logic [LED_W-1:0] r_led;
  logic [SW_W-1:0]  r_sw_s1, r_sw_s2;
  logic [31:0]      r_count, r_cmp, r_rdata;
  logic [2:0]       r_ctrl;
  logic             r_pend;

  logic             w_hit, w_wr, w_rd, w_match, w_w1c;
  logic [13:0]      w_sel;
  logic [31:0]      w_bmask, w_rsel;
  logic             w_unused;

  assign w_hit    = data_sram_en && (data_sram_addr[31:16] == BASE_HI);
  assign w_sel    = data_sram_addr[15:2];
  assign w_wr     = w_hit && (data_sram_wen != 4'd0);
  assign w_rd     = w_hit && (data_sram_wen == 4'd0);
  assign w_match  = r_ctrl[0] && (r_count == r_cmp);
  assign w_w1c    = w_wr && (w_sel == A_STAT) && data_sram_wen[0] && data_sram_wdata[0];
  assign w_unused = &{1'b0, data_sram_addr[1:0]};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_lane
      assign w_bmask[8*g +: 8] = {8{data_sram_wen[g]}};
    end
  endgenerate

  always_comb begin
    w_rsel = '0;
    case (w_sel)
      A_LED:   w_rsel = 32'(r_led);
      A_SW:    w_rsel = 32'(r_sw_s2);
      A_COUNT: w_rsel = r_count;
      A_CMP:   w_rsel = r_cmp;
      A_CTRL:  w_rsel = {29'd0, r_ctrl};
      A_STAT:  w_rsel = {31'd0, r_pend};
      default: w_rsel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_led   <= '0;
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_count <= '0;
      r_cmp   <= 32'hFFFF_FFFF;
      r_ctrl  <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      r_rdata <= w_rd ? w_rsel : '0;

      if (w_wr && w_sel == A_LED)
        r_led <= (r_led & ~w_bmask[LED_W-1:0]) | (data_sram_wdata[LED_W-1:0] & w_bmask[LED_W-1:0]);

      // A CPU write to COUNT overrides the increment; match still used the old value.
      if (w_wr && w_sel == A_COUNT)
        r_count <= (r_count & ~w_bmask) | (data_sram_wdata & w_bmask);
      else if (r_ctrl[0])
        r_count <= (w_match && r_ctrl[2]) ? 32'd0 : r_count + 32'd1;

      if (w_wr && w_sel == A_CMP)
        r_cmp <= (r_cmp & ~w_bmask) | (data_sram_wdata & w_bmask);

      if (w_wr && w_sel == A_CTRL)
        r_ctrl <= (r_ctrl & ~w_bmask[2:0]) | (data_sram_wdata[2:0] & w_bmask[2:0]);

      if (w_match)
        r_pend <= 1'b1;
      else if (w_w1c)
        r_pend <= 1'b0;
    end
  end

  assign data_sram_rdata = r_rdata;
  assign led             = r_led;
  assign timer_int       = r_pend & r_ctrl[1];

endmodule
